// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan driver.
package seg_pkg;

    typedef logic [6:0] seg_t;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] val;
    } digit_t;

    localparam seg_t SEG_OFF = 7'h7F;

    typedef enum logic { ST_ON, ST_GAP } scan_st_t;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: active-low {a..g} pattern for one hex nibble.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] val_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (val_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode seven-segment driver with
// per-digit registers, lit slots separated by an all-off anti-ghosting gap.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int REFRESH_DIV  = 100000,
    parameter  int BLANK_CYCLES = 2,
    localparam int AW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2((REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES) + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_val,
    input  logic                  wr_blank,
    input  logic                  wr_dp,
    output logic [6:0]            segments,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  frame_start
);

    digit_t [NUM_DIGITS-1:0] dig_q;
    scan_st_t                st_q, st_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    seg_q, seg_d, hex_seg;
    logic                    dp_q, dp_d, fs_q, fs_d;
    digit_t                  cur;
    logic                    last, adv, lit;

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx_q == AW'(i)) cur = dig_q[i];
    end

    hex_to_seg u_hex (.val_i(cur.val), .seg_o(hex_seg));

    // idx only advances when a lit slot is finished, i.e. leaving GAP or leaving ON with no gap
    always_comb begin
        last  = cnt_q == (st_q == ST_ON ? CW'(REFRESH_DIV - 1) : CW'(BLANK_CYCLES - 1));
        adv   = last && (st_q == ST_GAP || BLANK_CYCLES == 0);
        st_d  = last ? ((st_q == ST_ON && BLANK_CYCLES > 0) ? ST_GAP : ST_ON) : st_q;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        idx_d = !adv ? idx_q : (idx_q == AW'(NUM_DIGITS - 1) ? '0 : idx_q + AW'(1));
        lit   = st_q == ST_ON && !cur.blank;
        an_d  = st_q == ST_ON ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d = lit ? hex_seg : SEG_OFF;
        dp_d  = !(lit && cur.dp);
        fs_d  = st_q == ST_ON && idx_q == '0 && cnt_q == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_ON;
            idx_q <= '0;
            cnt_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fs_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '{blank: 1'b1, dp: 1'b0, val: 4'h0};
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= fs_d;
            // out-of-range addresses match no digit and are dropped
            for (int i = 0; i < NUM_DIGITS; i++)
                if (wr_en && wr_addr == AW'(i)) dig_q[i] <= '{blank: wr_blank, dp: wr_dp, val: wr_val};
        end
    end

    assign segments    = seg_q;
    assign dp_n        = dp_q;
    assign anode       = an_q;
    assign frame_start = fs_q;

endmodule
